// File: rtl/draw_dynamic_obst_array.sv
// Overlays a horizontally bouncing column of OBST_NUM rectangles on the pixel stream, one-cycle stage.
// Optional collision detection against the player sprite is compiled in with `define DYN_OBST_COLLISION_EN.
module draw_dynamic_obst_array #(
  parameter int          WIDTH           = 50,
  parameter int          HEIGHT          = 50,
  parameter logic [11:0] RECT_RGB        = 12'hB59,
  parameter int          OBST_NUM        = 3,
  parameter int          OBST_SEPARATION = 100,
  parameter int          X_MIN           = 100,
  parameter int          X_MAX           = 700,
  parameter int          SPEED           = 2,
  parameter int          FRAME_DIV       = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] y_pos,
  input  logic        move_en,
  input  logic        player_px,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblank_out,
  output logic        vblank_out,
  output logic [11:0] rgb_out,
  output logic [10:0] x_pos_out,
  output logic        collision
);

  localparam logic [11:0] W12      = 12'(WIDTH);
  localparam logic [11:0] H12      = 12'(HEIGHT);
  localparam logic [11:0] XMIN12   = 12'(X_MIN);
  localparam logic [11:0] XLIM12   = 12'(X_MAX - WIDTH);
  localparam logic [11:0] SPD12    = 12'(SPEED);
  localparam logic [5:0]  DIV_LAST = 6'(FRAME_DIV - 1);

  typedef enum logic [1:0] {STOP = 2'd0, RIGHT = 2'd1, LEFT = 2'd2} state_t;

  state_t      state_q, state_nxt;
  logic [10:0] x_q, x_nxt, y_q;
  logic        dir_q, dir_nxt;
  logic [5:0]  cnt_q, cnt_nxt;
  logic        vblank_q;
  logic        tick;
  logic        active;
  logic        obst_px;

  logic [10:0] hcount_p1, vcount_p1, x_pos_p1;
  logic        hsync_p1, vsync_p1, hblank_p1, vblank_p1;
  logic [11:0] rgb_p1;

  // Saturating steps: clamp to the travel limits instead of overshooting.
  function automatic logic [10:0] step_right(input logic [10:0] x);
    logic [11:0] s;
    s = {1'b0, x} + SPD12;
    return (s >= XLIM12) ? XLIM12[10:0] : s[10:0];
  endfunction

  function automatic logic [10:0] step_left(input logic [10:0] x);
    return ({1'b0, x} <= XMIN12 + SPD12) ? XMIN12[10:0] : x - SPD12[10:0];
  endfunction

  assign tick   = vblank_in & ~vblank_q;
  assign active = ~hblank_in & ~vblank_in;

  always_comb begin
    state_nxt = state_q;
    x_nxt     = x_q;
    dir_nxt   = dir_q;
    cnt_nxt   = cnt_q;
    if (tick) begin
      case (state_q)
        STOP: if (move_en) state_nxt = dir_q ? RIGHT : LEFT;
        RIGHT, LEFT: begin
          if (!move_en) begin
            state_nxt = STOP;
          end else if (cnt_q == DIV_LAST) begin
            cnt_nxt = '0;
            if (state_q == RIGHT) begin
              x_nxt = step_right(x_q);
              if ({1'b0, x_nxt} == XLIM12) begin
                dir_nxt   = 1'b0;
                state_nxt = LEFT;
              end
            end else begin
              x_nxt = step_left(x_q);
              if ({1'b0, x_nxt} == XMIN12) begin
                dir_nxt   = 1'b1;
                state_nxt = RIGHT;
              end
            end
          end else begin
            cnt_nxt = cnt_q + 6'd1;
          end
        end
        default: state_nxt = STOP;
      endcase
    end
  end

  // Bounds widened to 12 bits so x+WIDTH and y+k*SEP cannot wrap.
  always_comb begin
    logic [11:0] top;
    top     = '0;
    obst_px = 1'b0;
    for (int k = 0; k < OBST_NUM; k++) begin
      top = {1'b0, y_q} + 12'(k * OBST_SEPARATION);
      if (({1'b0, hcount_in} >= {1'b0, x_q}) && ({1'b0, hcount_in} < {1'b0, x_q} + W12) &&
          ({1'b0, vcount_in} >= top) && ({1'b0, vcount_in} < top + H12))
        obst_px = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q  <= STOP;
      x_q      <= 11'(X_MIN);
      y_q      <= '0;
      dir_q    <= 1'b1;
      cnt_q    <= '0;
      vblank_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      x_q      <= x_nxt;
      dir_q    <= dir_nxt;
      cnt_q    <= cnt_nxt;
      vblank_q <= vblank_in;
      if (tick) y_q <= y_pos;
    end
  end

  // Stage p1: timing delayed one clock, composited pixel.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      hcount_p1 <= '0;
      vcount_p1 <= '0;
      hsync_p1  <= 1'b0;
      vsync_p1  <= 1'b0;
      hblank_p1 <= 1'b0;
      vblank_p1 <= 1'b0;
      rgb_p1    <= '0;
      x_pos_p1  <= '0;
    end else begin
      hcount_p1 <= hcount_in;
      vcount_p1 <= vcount_in;
      hsync_p1  <= hsync_in;
      vsync_p1  <= vsync_in;
      hblank_p1 <= hblank_in;
      vblank_p1 <= vblank_in;
      rgb_p1    <= (active && obst_px) ? RECT_RGB : rgb_in;
      x_pos_p1  <= x_q;
    end
  end

  assign hcount_out = hcount_p1;
  assign vcount_out = vcount_p1;
  assign hsync_out  = hsync_p1;
  assign vsync_out  = vsync_p1;
  assign hblank_out = hblank_p1;
  assign vblank_out = vblank_p1;
  assign rgb_out    = rgb_p1;
  assign x_pos_out  = x_pos_p1;

`ifdef DYN_OBST_COLLISION_EN
  logic hit_now;
  logic hit_flag_q;
  logic coll_p1;

  assign hit_now = player_px & obst_px & active;

  // A hit on the tick cycle itself seeds the next frame's flag.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      hit_flag_q <= 1'b0;
      coll_p1    <= 1'b0;
    end else if (tick) begin
      coll_p1    <= hit_flag_q;
      hit_flag_q <= hit_now;
    end else begin
      coll_p1 <= 1'b0;
      if (hit_now) hit_flag_q <= 1'b1;
    end
  end

  assign collision = coll_p1;
`else
  logic unused_player_px;
  assign unused_player_px = player_px;
  assign collision        = 1'b0;
`endif

endmodule

// File: tb/tb_draw_dynamic_obst_array.sv
// Scoreboard bench for draw_dynamic_obst_array: randomized frames checked against a behavioural model.
module tb_draw_dynamic_obst_array;

  localparam int          WIDTH     = 50;
  localparam int          HEIGHT    = 50;
  localparam logic [11:0] RECT_RGB  = 12'hB59;
  localparam int          OBST_NUM  = 3;
  localparam int          SEP       = 100;
  localparam int          XMIN      = 100;
  localparam int          XMAX      = 700;
  localparam int          SPEED     = 7;
  localparam int          FRAME_DIV = 3;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [10:0] xpos;
    logic        coll;
  } out_t;

  logic        pclk;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, y_pos;
  logic        hsync_in, vsync_in, hblank_in, vblank_in, move_en, player_px;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out, x_pos_out;
  logic        hsync_out, vsync_out, hblank_out, vblank_out, collision;
  logic [11:0] rgb_out;

  out_t exp_q[$];
  int   vectors;
  int   miscompares;

  int   m_x, m_y, m_cnt;
  bit   m_dir_right, m_moving, m_vbprev, m_flag;

  draw_dynamic_obst_array #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .RECT_RGB(RECT_RGB), .OBST_NUM(OBST_NUM),
    .OBST_SEPARATION(SEP), .X_MIN(XMIN), .X_MAX(XMAX), .SPEED(SPEED), .FRAME_DIV(FRAME_DIV)
  ) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
    .rgb_in(rgb_in), .y_pos(y_pos), .move_en(move_en), .player_px(player_px),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblank_out(hblank_out), .vblank_out(vblank_out),
    .rgb_out(rgb_out), .x_pos_out(x_pos_out), .collision(collision)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference model: evaluates the current inputs, queues the next-cycle output, advances state.
  task automatic model_push();
    out_t e;
    bit   hit, act, tk, phit;
    int   h, v, top;
    e = '0;
    if (!rst) begin
      m_x = XMIN; m_y = 0; m_cnt = 0;
      m_dir_right = 1'b1; m_moving = 1'b0; m_vbprev = 1'b0; m_flag = 1'b0;
    end else begin
      h = int'(hcount_in);
      v = int'(vcount_in);
      hit = 1'b0;
      for (int k = 0; k < OBST_NUM; k++) begin
        top = m_y + k * SEP;
        if (h >= m_x && h < m_x + WIDTH && v >= top && v < top + HEIGHT) hit = 1'b1;
      end
      act   = !hblank_in && !vblank_in;
      e.h   = hcount_in;   e.v  = vcount_in;
      e.hs  = hsync_in;    e.vs = vsync_in;
      e.hb  = hblank_in;   e.vb = vblank_in;
      e.rgb = (hit && act) ? RECT_RGB : rgb_in;
      e.xpos = 11'(m_x);
      tk   = vblank_in && !m_vbprev;
      phit = player_px && hit && act;
`ifdef DYN_OBST_COLLISION_EN
      e.coll = tk ? m_flag : 1'b0;
      m_flag = tk ? phit : (m_flag || phit);
`else
      e.coll = 1'b0;
`endif
      m_vbprev = vblank_in;
      if (tk) begin
        m_y = int'(y_pos);
        if (!m_moving) m_moving = move_en;
        else if (!move_en) m_moving = 1'b0;
        else begin
          m_cnt++;
          if (m_cnt == FRAME_DIV) begin
            m_cnt = 0;
            if (m_dir_right) begin
              m_x = m_x + SPEED;
              if (m_x >= XMAX - WIDTH) begin m_x = XMAX - WIDTH; m_dir_right = 1'b0; end
            end else begin
              m_x = m_x - SPEED;
              if (m_x <= XMIN) begin m_x = XMIN; m_dir_right = 1'b1; end
            end
          end
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    model_push();
    @(negedge pclk);
  endtask

  task automatic rand_timing();
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
    hblank_in = ($urandom_range(0, 3) == 0);
    rgb_in    = 12'($urandom);
    player_px = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 3) != 0) begin
      hcount_in = 11'(m_x - 5 + $urandom_range(0, 70));
      vcount_in = 11'(m_y + $urandom_range(0, 300));
    end else begin
      hcount_in = 11'($urandom);
      vcount_in = 11'($urandom);
    end
  endtask

  // One short frame: active cycles then two vblank cycles (first one is the tick).
  task automatic frame(input int len);
    for (int i = 0; i < len; i++) begin
      rand_timing();
      vblank_in = (i >= len - 2);
      cycle();
    end
  endtask

  task automatic pixel(input int h, input int v, input bit pp);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblank_in = 1'b0;   vblank_in = 1'b0;
    rgb_in    = 12'($urandom); player_px = pp;
    cycle();
  endtask

  always begin
    out_t got, e;
    @(posedge pclk);
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {hcount_out, vcount_out, hsync_out, vsync_out, hblank_out, vblank_out,
             rgb_out, x_pos_out, collision};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL vec%0d: got h=%0d v=%0d hs/vs/hb/vb=%b%b%b%b rgb=%h x=%0d coll=%b; need h=%0d v=%0d hs/vs/hb/vb=%b%b%b%b rgb=%h x=%0d coll=%b",
                 vectors, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.rgb, got.xpos, got.coll,
                 e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb, e.xpos, e.coll);
      end
    end
  end

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; move_en = 1'b0; y_pos = '0;
    hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    hblank_in = 1'b0; vblank_in = 1'b0; rgb_in = '0; player_px = 1'b0;

    // Reset held three cycles with noise on the inputs.
    for (int i = 0; i < 3; i++) begin rand_timing(); vblank_in = 1'($urandom_range(0, 1)); cycle(); end
    rst = 1'b1;
    vblank_in = 1'b0;
    for (int i = 0; i < 4; i++) begin rand_timing(); vblank_in = 1'b0; cycle(); end

    // Latch y=50 with motion disabled, then probe drawing corners.
    y_pos = 11'd50;
    frame(6);
    frame(6);
    pixel(120, 60, 0);  pixel(120, 120, 0); pixel(120, 260, 0); pixel(150, 60, 0);
    pixel(149, 60, 0);  pixel(100, 50, 0);  pixel(99, 50, 0);   pixel(120, 99, 0);
    pixel(120, 100, 0); pixel(120, 150, 0); pixel(120, 299, 0); pixel(120, 300, 0);

    // Collision: one hit then a tick; then a frame with player outside obstacles.
    pixel(110, 60, 1);
    pixel(300, 60, 0);
    for (int i = 0; i < 3; i++) begin hcount_in = 11'(200 + i); player_px = 1'b0; vblank_in = 1'b1; cycle(); end
    pixel(300, 60, 1);  pixel(110, 130, 1); pixel(99, 60, 1);
    for (int i = 0; i < 3; i++) begin vblank_in = 1'b1; player_px = 1'b0; cycle(); end
    pixel(200, 200, 0);

    // Long run with motion: covers both bounces, divider, stop frames and y changes.
    for (int f = 0; f < 560; f++) begin
      move_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 4) == 0) y_pos = 11'($urandom_range(0, 400));
      frame(int'($urandom_range(4, 8)));
    end

    // Reset in the middle of a moving frame.
    move_en = 1'b1;
    for (int f = 0; f < 20; f++) frame(5);
    rand_timing(); vblank_in = 1'b0; cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_timing(); vblank_in = 1'b0; cycle(); end
    rst = 1'b1;
    for (int f = 0; f < 40; f++) begin
      move_en = ($urandom_range(0, 5) != 0);
      frame(int'($urandom_range(4, 7)));
    end

    rand_timing(); vblank_in = 1'b0; model_push();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge pclk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d outputs still pending, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
